// File: rtl/flag_unit_arbiter.sv
// Two-requester flag unit: one shared zero checker and one shared equality checker.
// An arbiter grants one requester at a time. The result is registered once, then held until the owner accepts it.

module check_zero32 (
    input  logic [31:0] x,
    output logic        is_zero
);
    assign is_zero = (x == 32'd0);
endmodule

module check_equal32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_equal
);
    assign is_equal = (a == b);
endmodule

module flag_unit_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic        req_op0,
    input  logic        req_op1,
    input  logic [31:0] req_x0,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_y0,
    input  logic [31:0] req_y1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic        rsp_flag,
    output logic        busy,
    output logic [7:0]  op_count
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t      state, state_next;
    logic        owner, last_grant, op_q;
    logic [31:0] x_q, y_q;
    logic        grant_any, grant_idx, accept, rsp_done;
    logic        zero_flag, equal_flag;

    check_zero32 u_zero (
        .x       (x_q),
        .is_zero (zero_flag)
    );

    check_equal32 u_equal (
        .a        (x_q),
        .b        (y_q),
        .is_equal (equal_flag)
    );

    // A tie goes to the requester that did not win last time, or always to 0 without round-robin.
    always_comb begin
        grant_any = |req_valid;
        grant_idx = 1'b0;
        case (req_valid)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = RR_EN ? ~last_grant : 1'b0;
            default: grant_idx = 1'b0;
        endcase
    end

    assign accept    = (state == IDLE) && grant_any;
    assign rsp_done  = (state == RESP) && rsp_ready[owner];
    assign req_ready = accept ? (2'b01 << grant_idx) : 2'b00;
    assign rsp_valid = (state == RESP) ? (2'b01 << owner) : 2'b00;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EVAL;
            EVAL:    state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are captured only on the accept edge; the flag is captured only in EVAL and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= 1'b0;
            x_q        <= 32'd0;
            y_q        <= 32'd0;
            rsp_flag   <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            if (accept) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
                op_q       <= grant_idx ? req_op1 : req_op0;
                x_q        <= grant_idx ? req_x1 : req_x0;
                y_q        <= grant_idx ? req_y1 : req_y0;
            end
            if (state == EVAL) begin
                rsp_flag <= op_q ? equal_flag : zero_flag;
            end
            if (rsp_done) begin
                op_count <= op_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_flag_unit_arbiter.sv
// Randomized and directed bench for flag_unit_arbiter.
// A transaction-level model predicts every visible output cycle by cycle.

module tb_flag_unit_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic        req_op0, req_op1, rsp_flag, busy;
    logic [31:0] req_x0, req_x1, req_y0, req_y1;
    logic [7:0]  op_count;

    logic [1:0]  fp_req_valid, fp_req_ready, fp_rsp_valid, fp_rsp_ready;
    logic        fp_rsp_flag, fp_busy;
    logic [7:0]  fp_op_count;

    int total = 0;
    int bad   = 0;

    // Model of the round-robin instance: at most one transaction in flight.
    bit       m_pending, m_owner, m_flag, m_last;
    int       m_age;
    bit [7:0] m_count;

    logic [1:0] obs_req_ready, obs_rsp_valid;
    logic       obs_rsp_flag;
    logic [7:0] obs_op_count;

    always #5 clk = ~clk;

    flag_unit_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_flag(rsp_flag),
        .busy(busy), .op_count(op_count)
    );

    flag_unit_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(fp_req_valid), .req_ready(fp_req_ready),
        .req_op0(1'b0), .req_op1(1'b0),
        .req_x0(32'd0), .req_x1(32'd0), .req_y0(32'd0), .req_y1(32'd0),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_flag(fp_rsp_flag),
        .busy(fp_busy), .op_count(fp_op_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_pending = 1'b0;
        m_owner   = 1'b0;
        m_flag    = 1'b0;
        m_last    = 1'b1;
        m_age     = 0;
        m_count   = 8'd0;
    endtask

    // Called at a falling edge: drive, check against the model, advance the model across the next rising edge.
    task automatic applyStimulus(input logic [1:0] v, input logic op0, input logic [31:0] x0, input logic [31:0] y0,
                                 input logic op1, input logic [31:0] x1, input logic [31:0] y1, input logic [1:0] rr);
        logic [1:0]  e_ready, e_valid;
        bit          g_any, g, g_op;
        logic [31:0] g_x, g_y;
        req_valid = v; req_op0 = op0; req_x0 = x0; req_y0 = y0;
        req_op1 = op1; req_x1 = x1; req_y1 = y1; rsp_ready = rr;
        #1;
        g_any = 1'b0;
        g     = 1'b0;
        if (!m_pending) begin
            g_any = (v != 2'b00);
            if (v == 2'b10) g = 1'b1;
            else if (v == 2'b11) g = (m_last == 1'b0);
        end
        e_ready = g_any ? (g ? 2'b10 : 2'b01) : 2'b00;
        e_valid = (m_pending && m_age >= 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        obs_req_ready = req_ready;
        obs_rsp_valid = rsp_valid;
        obs_rsp_flag  = rsp_flag;
        obs_op_count  = op_count;
        checkOutput("req_ready", {30'd0, req_ready}, {30'd0, e_ready});
        checkOutput("rsp_valid", {30'd0, rsp_valid}, {30'd0, e_valid});
        checkOutput("busy", {31'd0, busy}, {31'd0, m_pending});
        checkOutput("op_count", {24'd0, op_count}, {24'd0, m_count});
        if (e_valid != 2'b00) checkOutput("rsp_flag", {31'd0, rsp_flag}, {31'd0, m_flag});
        if (!m_pending) begin
            if (g_any) begin
                g_op = g ? op1 : op0;
                g_x  = g ? x1 : x0;
                g_y  = g ? y1 : y0;
                m_pending = 1'b1;
                m_owner   = g;
                m_last    = g;
                m_flag    = g_op ? (g_x == g_y) : (g_x == 32'd0);
                m_age     = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (rr[m_owner]) begin
            m_pending = 1'b0;
            m_count   = m_count + 8'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle(input logic [1:0] rr);
        applyStimulus(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, rr);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [1:0]  v, rr;
        logic        op0, op1;
        logic [31:0] x0, x1, y0, y1;

        req_valid = 2'b00; rsp_ready = 2'b00; req_op0 = 1'b0; req_op1 = 1'b0;
        req_x0 = 32'd0; req_x1 = 32'd0; req_y0 = 32'd0; req_y1 = 32'd0;
        fp_req_valid = 2'b00; fp_rsp_ready = 2'b00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_flag", {31'd0, rsp_flag}, 32'd0);
        checkOutput("rst_op_count", {24'd0, op_count}, 32'd0);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);

        // Requester 0 zero test on x=0.
        applyStimulus(2'b01, 1'b0, 32'h0, 32'h1234, 1'b0, 32'd0, 32'd0, 2'b01);
        idleCycle(2'b01);
        checkOutput("r0_eval_valid", {30'd0, obs_rsp_valid}, 32'd0);
        idleCycle(2'b01);
        checkOutput("r0_valid", {30'd0, obs_rsp_valid}, 32'h1);
        checkOutput("r0_flag", {31'd0, obs_rsp_flag}, 32'h1);
        idleCycle(2'b00);
        checkOutput("r0_count", {24'd0, obs_op_count}, 32'h1);

        // Requester 1 equality tests.
        applyStimulus(2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEE, 2'b10);
        idleCycle(2'b10);
        idleCycle(2'b10);
        checkOutput("r1_ne_valid", {30'd0, obs_rsp_valid}, 32'h2);
        checkOutput("r1_ne_flag", {31'd0, obs_rsp_flag}, 32'h0);
        applyStimulus(2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
        idleCycle(2'b10);
        idleCycle(2'b10);
        checkOutput("r1_eq_flag", {31'd0, obs_rsp_flag}, 32'h1);

        // Stall in RESP with both requests pending and the non-owner accepting.
        applyStimulus(2'b01, 1'b0, 32'h1234, 32'd0, 1'b0, 32'd0, 32'd0, 2'b00);
        applyStimulus(2'b11, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 2'b10);
            checkOutput("stall_valid", {30'd0, obs_rsp_valid}, 32'h1);
            checkOutput("stall_flag", {31'd0, obs_rsp_flag}, 32'h0);
            checkOutput("stall_ready", {30'd0, obs_req_ready}, 32'h0);
        end
        applyStimulus(2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 2'b01);
        idleCycle(2'b00);
        checkOutput("stall_count", {24'd0, obs_op_count}, 32'h4);

        // Reset during EVAL: outputs clear immediately and the operation vanishes.
        applyStimulus(2'b01, 1'b1, 32'h5, 32'h5, 1'b0, 32'd0, 32'd0, 2'b00);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("mid_rst_flag", {31'd0, rsp_flag}, 32'd0);
        checkOutput("mid_rst_count", {24'd0, op_count}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        repeat (3) idleCycle(2'b11);

        // Both requesters always valid: the first tie after reset goes to 0, then alternation.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 1'b0, 32'd0, 32'd0, 1'b0, 32'd1, 32'd0, 2'b11);
            checkOutput("rr_grant", {30'd0, obs_req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
            applyStimulus(2'b11, 1'b0, 32'd0, 32'd0, 1'b0, 32'd1, 32'd0, 2'b11);
            applyStimulus(2'b11, 1'b0, 32'd0, 32'd0, 1'b0, 32'd1, 32'd0, 2'b11);
            checkOutput("rr_owner", {30'd0, obs_rsp_valid}, (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        idleCycle(2'b00);

        // Fixed-priority instance: requester 1 never wins a tie.
        fp_req_valid = 2'b11;
        fp_rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 checkOutput("fp_grant", {30'd0, fp_req_ready}, 32'h1);
            @(posedge clk); @(negedge clk);
            #1 checkOutput("fp_eval_valid", {30'd0, fp_rsp_valid}, 32'h0);
            @(posedge clk); @(negedge clk);
            #1 checkOutput("fp_owner", {30'd0, fp_rsp_valid}, 32'h1);
            @(posedge clk); @(negedge clk);
        end
        #1;
        checkOutput("fp_count", {24'd0, fp_op_count}, 32'h4);
        checkOutput("fp_starved", {30'd0, fp_req_ready}, 32'h1);
        fp_req_valid = 2'b00;
        @(negedge clk);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            v   = 2'($urandom_range(0, 3));
            rr  = 2'($urandom_range(0, 3));
            op0 = 1'($urandom_range(0, 1));
            op1 = 1'($urandom_range(0, 1));
            x0  = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            x1  = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            y0  = ($urandom_range(0, 1) == 0) ? x0 : (x0 ^ (32'd1 << $urandom_range(0, 31)));
            y1  = ($urandom_range(0, 1) == 0) ? x1 : (x1 ^ (32'd1 << $urandom_range(0, 31)));
            applyStimulus(v, op0, x0, y0, op1, x1, y1, rr);
        end

        // Counter wrap after 256 completions.
        pulseReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(2'b01, 1'b0, i, 32'd0, 1'b0, 32'd0, 32'd0, 2'b01);
            idleCycle(2'b01);
            idleCycle(2'b01);
        end
        idleCycle(2'b00);
        checkOutput("wrap_count", {24'd0, obs_op_count}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
